serial_full_subtractor: RTL and testbench
=========================================

// Module: serial_full_subtractor
// PURPOSE
//  Bit-serial N-bit subtractor (A - B), the inverse operation of the board's combinational full adder.
//  Operands enter LSB-first, one bit pair per press of the step button.
//  A registered borrow chains the bits, and a shift register accumulates the difference for the LEDs.
//  Top-level board block: pmod buttons in (active-low), LEDs out (active-high).
// PARAMETERS
//  WIDTH       4        operand/difference width in bits (2..8)
//  DEB_CYCLES  250000   debounce stable-count in clk cycles (used only with DEBOUNCE_EN)
// PORTS
//  clk      in   1      system clock; the only clock
//  rst_n    in   1      asynchronous, active-low reset
//  a_n      in   1      current bit of operand A, active-low (pmod)
//  b_n      in   1      current bit of operand B, active-low (pmod)
//  step_n   in   1      step button, active-low; each press consumes one bit pair
//  clear_n  in   1      clear button, active-low; returns the block to IDLE
//  led      out  WIDTH  difference register, bit0 = LSB
//  borrow   out  1      borrow flop; after DONE, 1 means A < B
//  done     out  1      high in DONE state
// BEHAVIOUR
//  Reset: asynchronous assert on rst_n low; all flops clear.
//   led=0, borrow=0, done=0, bit count=0, state=IDLE.
//  Input handling: a_n, b_n, step_n, clear_n each pass through a 2-flop synchronizer.
//   a = ~a_n_sync, b = ~b_n_sync.
//  step_pulse: 1-cycle pulse on the synchronized falling edge of step_n (press); release is ignored.
//  clear_lvl: synchronized ~clear_n, acted on as a level.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE  -> SHIFT  on step_pulse; that pulse is processed as bit 0.
//   SHIFT -> DONE   on the step_pulse that brings the count to WIDTH.
//   DONE  -> IDLE   only on clear_lvl; step_pulse is ignored in DONE.
//   Any state -> IDLE on clear_lvl, which also zeroes led, borrow and count.
//  Per accepted step, one cycle after the pulse:
//   d = a ^ b ^ borrow
//   borrow <= (~a & b) | (~(a ^ b) & borrow)
//   led <= {d, led[WIDTH-1:1]}   (right shift; after WIDTH steps led[0] = LSB)
//   count <= count + 1           (width $clog2(WIDTH+1), saturates at WIDTH)
//  done rises in the same cycle that led holds the final value.
//  Result is led = (A - B) mod 2^WIDTH, with borrow = (A < B).
//  Boundary cases:
//   clear_lvl and step_pulse in the same cycle: clear wins; the step is dropped.
//   Held step button: counts once per press.
//   Operands may change between presses; they are sampled only on step_pulse.
//   Reset mid-operation: immediate return to the reset values above.
//  Latency: button edge to LED update is 3 clk (2 sync + 1 register), plus debounce time when enabled.
// CONFIGURATION
//  DEBOUNCE_EN defined: step_n and clear_n must be stable for DEB_CYCLES consecutive
//   synchronized samples before their filtered level changes.
//   Edges are detected on the filtered level.
//  DEBOUNCE_EN undefined: no filter; edges are taken directly from the synchronized signal.
//   DEB_CYCLES is unused.
// STRUCTURE
//  Package serial_sub_pkg holds:
//   state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
//   the count-width function
//  Sub-module btn_cond:
//   one instance per button
//   synchronizer + optional debounce + falling-edge pulse
//   outputs: level and press pulse
//  Top level holds the FSM, borrow flop, shift register and counter.
// TESTING (WIDTH=4, DEBOUNCE_EN off unless stated)
//  A=0101, B=0011, four steps -> led=0010, borrow=0, done=1.
//  A=0011, B=0101, four steps -> led=1110, borrow=1, done=1.
//  A=1111, B=1111 -> led=0000, borrow=0.
//   A=0000, B=0001 -> led=1111, borrow=1.
//  Done handling:
//   after done, a 5th step leaves led/borrow unchanged;
//   clear -> led=0, borrow=0, done=0, state IDLE.
//  Interruptions:
//   clear and step in the same cycle after 2 steps -> all zero, count=0;
//   rst_n low mid-SHIFT -> all outputs 0 asynchronously.
//  DEBOUNCE_EN on, DEB_CYCLES=8:
//   5-cycle glitch on step_n -> no step;
//   a 12-cycle press -> exactly one step.

Source files
------------

// File: rtl/serial_full_subtractor_pkg.sv
// +--------------------------------------------------------------------------+
// | Module  : serial_sub_pkg                                                 |
// | Purpose : Shared types and helpers for the bit-serial subtractor.        |
// |           State encodings and the bit-counter width function.            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // The bit counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_full_subtractor_if.sv
// +--------------------------------------------------------------------------+
// | Module  : serial_full_subtractor_if                                      |
// | Purpose : Board-side signal bundle of the serial subtractor.             |
// |   a_n, b_n       : operand bits, active-low (pmod)                       |
// |   step_n, clear_n: buttons, active-low                                   |
// |   led            : difference register, bit0 = LSB                       |
// |   borrow, done   : borrow flop and completion flag                       |
// |   master drives the buttons/operands, slave is the subtractor.           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

interface serial_full_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             a_n;
  logic             b_n;
  logic             step_n;
  logic             clear_n;
  logic [WIDTH-1:0] led;
  logic             borrow;
  logic             done;

  modport master (
    output a_n, b_n, step_n, clear_n,
    input  led, borrow, done
  );

  modport slave (
    input  a_n, b_n, step_n, clear_n,
    output led, borrow, done
  );
endinterface

`default_nettype wire

// File: rtl/serial_full_subtractor_btn_cond.sv
// +--------------------------------------------------------------------------+
// | Module  : btn_cond                                                       |
// | Purpose : Button conditioner: 2-flop synchronizer, optional debounce     |
// |           filter, and a 1-cycle pulse on each press.                     |
// |   clk, rst_n : clock, asynchronous active-low reset                      |
// |   btn_n_i    : raw button, active-low                                    |
// |   level_o    : conditioned level, 1 = pressed                            |
// |   press_o    : 1-cycle pulse on the press edge                           |
// | Macro   : DEBOUNCE_EN enables the DEB_CYCLES stability filter.           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module btn_cond #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o
);

  // The inverted (active-high) level is synchronized so that cleared flops
  // mean "not pressed" and no false press appears after reset.
  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic filt_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ~btn_n_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DCW = $clog2(DEB_CYCLES + 1);

  logic [DCW-1:0] deb_cnt_q;
  logic           filt_q;

  // The filtered level follows only after DEB_CYCLES consecutive samples
  // that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
      filt_q    <= 1'b0;
    end else if (sync2_q == filt_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DCW'(DEB_CYCLES - 1)) begin
      deb_cnt_q <= '0;
      filt_q    <= sync2_q;
    end else begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  assign filt_lvl = filt_q;
`else
  logic [31:0] deb_unused;
  assign deb_unused = DEB_CYCLES;
  assign filt_lvl   = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= filt_lvl;
    end
  end

  assign level_o = filt_lvl;
  assign press_o = filt_lvl & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/serial_full_subtractor.sv
// +--------------------------------------------------------------------------+
// | Module  : serial_full_subtractor                                         |
// | Purpose : Bit-serial A - B, LSB first, one bit pair per step press.      |
// |           Registered borrow chains the bits; a right-shift register      |
// |           collects the difference for the LEDs.                          |
// |   clk, rst_n : clock, asynchronous active-low reset                      |
// |   bus        : serial_full_subtractor_if.slave (buttons in, LEDs out)    |
// | Macro   : DEBOUNCE_EN enables debounce on step_n and clear_n.            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module serial_full_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 250000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  serial_full_subtractor_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);

  // Operand synchronizers; stored active-high.
  logic a_s1_q, a_s2_q;
  logic b_s1_q, b_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_q <= 1'b0;
      a_s2_q <= 1'b0;
      b_s1_q <= 1'b0;
      b_s2_q <= 1'b0;
    end else begin
      a_s1_q <= ~bus.a_n;
      a_s2_q <= a_s1_q;
      b_s1_q <= ~bus.b_n;
      b_s2_q <= b_s1_q;
    end
  end

  logic step_pulse;
  logic step_lvl_unused;
  logic clear_lvl;
  logic clear_press_unused;

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (bus.step_n),
    .level_o (step_lvl_unused),
    .press_o (step_pulse)
  );

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (bus.clear_n),
    .level_o (clear_lvl),
    .press_o (clear_press_unused)
  );

  state_t           state_q;
  logic [WIDTH-1:0] led_q, led_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q;
  logic             diff_bit;

  always_comb begin
    diff_bit = a_s2_q ^ b_s2_q ^ borrow_q;
    borrow_d = (~a_s2_q & b_s2_q) | (~(a_s2_q ^ b_s2_q) & borrow_q);
    led_d    = {diff_bit, led_q[WIDTH-1:1]};
    count_d  = (count_q == CW'(WIDTH)) ? count_q : count_q + 1'b1;
  end

  // Clear has priority over a coincident step, which is then dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      led_q    <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else if (clear_lvl) begin
      state_q  <= ST_IDLE;
      led_q    <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else if (step_pulse && (state_q != ST_DONE)) begin
      led_q    <= led_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      if (count_d == CW'(WIDTH)) begin
        state_q <= ST_DONE;
        done_q  <= 1'b1;
      end else begin
        state_q <= ST_SHIFT;
      end
    end
  end

  assign bus.led    = led_q;
  assign bus.borrow = borrow_q;
  assign bus.done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_full_subtractor.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_serial_full_subtractor                                      |
// | Purpose : Self-checking bench for serial_full_subtractor (WIDTH=4).      |
// |           Expected results are queued when an operation is driven and    |
// |           compared when the DUT raises done.                             |
// | Macro   : DEBOUNCE_EN adds the glitch / long-press filter scenarios.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_serial_full_subtractor;

  localparam int WIDTH = 4;
  localparam int DEB   = 8;
`ifdef DEBOUNCE_EN
  localparam int HOLD  = DEB + 6;
`else
  localparam int HOLD  = 4;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] led;
    logic             borrow;
    logic             done;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  serial_full_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_full_subtractor #(.WIDTH(WIDTH), .DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic a, input logic b);
    bus.a_n    = ~a;
    bus.b_n    = ~b;
    cycles(3);
    bus.step_n = 1'b0;
    cycles(HOLD);
    bus.step_n = 1'b1;
    cycles(HOLD);
  endtask

  task automatic do_clear();
    bus.clear_n = 1'b0;
    cycles(HOLD);
    bus.clear_n = 1'b1;
    cycles(HOLD);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_led"}, 32'(bus.led), 32'd0);
    check_val({tag, "_borrow"}, 32'(bus.borrow), 32'd0);
    check_val({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int   k;
    e.led    = a - b;
    e.borrow = (a < b);
    e.done   = 1'b1;
    sb_q.push_back(e);
    for (int i = 0; i < WIDTH; i++) begin
      press(a[i], b[i]);
      if (i == WIDTH - 2) check_val("done_early", 32'(bus.done), 32'd0);
    end
    k = 0;
    while (!bus.done && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) begin
      check_val("done_timeout", 32'(bus.done), 32'd1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      check_val($sformatf("led_%0h_%0h", a, b), 32'(bus.led), 32'(e.led));
      check_val($sformatf("borrow_%0h_%0h", a, b), 32'(bus.borrow), 32'(e.borrow));
      check_val($sformatf("done_%0h_%0h", a, b), 32'(bus.done), 32'(e.done));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-1:0] led_snap;
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.a_n     = 1'b1;
    bus.b_n     = 1'b1;
    bus.step_n  = 1'b1;
    bus.clear_n = 1'b1;
    cycles(3);
    check_zero("reset");
    rst_n = 1'b1;
    cycles(2);

    // Main function, including operands that change between presses.
    run_op(4'b0101, 4'b0011);
    do_clear();
    run_op(4'b0011, 4'b0101);

    // Extra step in DONE is ignored.
    press(1'b1, 1'b1);
    check_val("post_done_led", 32'(bus.led), 32'hE);
    check_val("post_done_borrow", 32'(bus.borrow), 32'd1);
    check_val("post_done_done", 32'(bus.done), 32'd1);
    do_clear();
    check_zero("clear");

    run_op(4'b1111, 4'b1111);
    do_clear();
    run_op(4'b0000, 4'b0001);
    do_clear();
    for (int r = 0; r < 2; r++) begin
      ra = WIDTH'($urandom_range(0, 15));
      rb = WIDTH'($urandom_range(0, 15));
      run_op(ra, rb);
      do_clear();
    end

`ifndef DEBOUNCE_EN
    // Button edge to LED update takes exactly three clocks.
    bus.a_n = 1'b0;
    bus.b_n = 1'b1;
    cycles(3);
    bus.step_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_val("lat_2clk", 32'(bus.led), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("lat_3clk", 32'(bus.led), 32'h8);
    bus.step_n = 1'b1;
    cycles(HOLD);
    do_clear();
`endif

    // Clear coinciding with a step after two steps: clear wins, count restarts.
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    bus.a_n     = 1'b0;
    bus.b_n     = 1'b0;
    cycles(3);
    bus.clear_n = 1'b0;
    bus.step_n  = 1'b0;
    cycles(HOLD);
    bus.clear_n = 1'b1;
    bus.step_n  = 1'b1;
    cycles(HOLD);
    check_zero("clr_step");
    run_op(4'b1001, 4'b0010);

    // Asynchronous reset in the middle of an operation.
    do_clear();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    run_op(4'b1100, 4'b0111);
    do_clear();

`ifdef DEBOUNCE_EN
    // A short glitch must not register; a long press counts exactly once.
    bus.a_n = 1'b0;
    bus.b_n = 1'b1;
    cycles(3);
    bus.step_n = 1'b0;
    cycles(5);
    bus.step_n = 1'b1;
    cycles(HOLD);
    check_val("glitch_led", 32'(bus.led), 32'd0);
    led_snap = bus.led;
    bus.step_n = 1'b0;
    cycles(12);
    bus.step_n = 1'b1;
    cycles(HOLD);
    check_val("long_press_led", 32'(bus.led), 32'(led_snap) | 32'h8);
    check_val("long_press_done", 32'(bus.done), 32'd0);
    do_clear();
`else
    led_snap = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
